// File: rtl/fp_operand_pairer.sv
// Pairs single-precision operands for an FP adder, classifies both operands,
// flushes denormals to signed zero and precomputes special-case sums.
module fp_operand_pairer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_cls_a,
    output logic [2:0]       out_cls_b,
    output logic             out_bypass,
    output logic [31:0]      out_bypass_result,
    output logic [CNT_W-1:0] pair_count
);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] HAVE_A = 2'd1;
    localparam logic [1:0] FULL   = 2'd2;

    localparam logic [2:0] CLS_NORM = 3'd0;
    localparam logic [2:0] CLS_ZERO = 3'd1;
    localparam logic [2:0] CLS_DEN  = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]  state;
    logic [31:0] a_raw;
    logic        take_in;
    logic        take_out;

    logic [2:0]  cls_a;
    logic [2:0]  cls_b;
    logic [31:0] flt_a;
    logic [31:0] flt_b;
    logic        byp;
    logic [31:0] byp_res;

    function automatic logic [2:0] classify(input logic [31:0] w);
        logic [2:0] c;
        if (w[30:23] == 8'h00)
            c = (w[22:0] == 23'd0) ? CLS_ZERO : CLS_DEN;
        else if (w[30:23] == 8'hFF)
            c = (w[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        else
            c = CLS_NORM;
        return c;
    endfunction

    assign in_ready  = (state != FULL);
    assign out_valid = (state == FULL);
    assign take_in   = in_valid && in_ready;
    assign take_out  = out_valid && out_ready;

    // Classify held A against incoming B and resolve the special-case sum
    always_comb begin
        logic a_zd;
        logic b_zd;
        logic a_inf;
        logic b_inf;
        cls_a   = classify(a_raw);
        cls_b   = classify(in_data);
        flt_a   = (cls_a == CLS_DEN) ? {a_raw[31], 31'd0} : a_raw;
        flt_b   = (cls_b == CLS_DEN) ? {in_data[31], 31'd0} : in_data;
        a_zd    = (cls_a == CLS_ZERO) || (cls_a == CLS_DEN);
        b_zd    = (cls_b == CLS_ZERO) || (cls_b == CLS_DEN);
        a_inf   = (cls_a == CLS_INF);
        b_inf   = (cls_b == CLS_INF);
        byp     = (cls_a != CLS_NORM) || (cls_b != CLS_NORM);
        byp_res = a_raw;
        if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
            (a_inf && b_inf && (a_raw[31] != in_data[31])))
            byp_res = QNAN;
        else if (a_inf)
            byp_res = a_raw;
        else if (b_inf)
            byp_res = in_data;
        else if (a_zd && b_zd)
            byp_res = {a_raw[31] & in_data[31], 31'd0};
        else if (a_zd)
            byp_res = in_data;
        else
            byp_res = a_raw;
    end

    // Pairing FSM, output pair registers and issued-pair counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= EMPTY;
            a_raw             <= 32'd0;
            out_a             <= 32'd0;
            out_b             <= 32'd0;
            out_cls_a         <= 3'd0;
            out_cls_b         <= 3'd0;
            out_bypass        <= 1'b0;
            out_bypass_result <= 32'd0;
            pair_count        <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (take_in) begin
                        a_raw <= in_data;
                        state <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (take_in) begin
                        out_a             <= flt_a;
                        out_b             <= flt_b;
                        out_cls_a         <= cls_a;
                        out_cls_b         <= cls_b;
                        out_bypass        <= byp;
                        out_bypass_result <= byp_res;
                        state             <= FULL;
                    end
                end
                FULL: begin
                    if (take_out) begin
                        pair_count <= pair_count + CNT_W'(1);
                        state      <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
